// File: rtl/fpacc_seq.sv
// fpacc_seq - floating-point accumulation sequencer.
//
// Initiator side of the fpadd start/done handshake. Samples arrive over a
// valid/ready input. The first sample of a block seeds the accumulator.
// Each further sample issues one fpadd operation of (running sum + sample).
// The block sum, sample count and timeout status then leave over a
// valid/ready output.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. A producer holds valid and its payload stable until that
// edge. Ready never depends combinationally on valid.
//
// Optional feature: define FPACC_SUB_EN to make in_sub negate the sample by
// flipping its sign bit. When the macro is undefined, in_sub is ignored.
//
// Parameters:
//   COUNT_W   width of the sample counter and out_count
//   TIMEOUT   max WAIT cycles before an fpadd operation is aborted (>= 2)
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   sample input (IEEE-754 single)
//   in_last, in_sub             end-of-block marker, negate request
//   add_start/add_a/add_b       fpadd operation request (a = running sum)
//   add_sum/add_done            fpadd result, level done flag
//   out_valid/out_ready         block result handshake
//   out_sum, out_count, err     block sum, saturating count, timeout flag
//   busy                        high in every state except ACCEPT
//   dbg_state                   current FSM state (0 ACCEPT, 1 ISSUE, 2 WAIT, 3 OUT)
module fpacc_seq #(
   parameter int COUNT_W = 8,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_data,
   input  logic               in_last,
   input  logic               in_sub,
   output logic               add_start,
   output logic [31:0]        add_a,
   output logic [31:0]        add_b,
   input  logic [31:0]        add_sum,
   input  logic               add_done,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_sum,
   output logic [COUNT_W-1:0] out_count,
   output logic               err,
   output logic               busy,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      OUT    = 2'd3
   } state_t;

   // The counter indexes WAIT cycles from 0 to TIMEOUT-1.
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

   state_t             state;
   state_t             state_nxt;
   logic               first;
   logic               last_q;
   logic               abort;
   logic               abort_nxt;
   logic [31:0]        acc;
   logic [31:0]        acc_nxt;
   logic [COUNT_W-1:0] count;
   logic [COUNT_W-1:0] count_nxt;
   logic [COUNT_W-1:0] count_inc;
   logic [TW-1:0]      wait_cnt;
   logic [31:0]        smp;
   logic               done_ok;

`ifdef FPACC_SUB_EN
   assign smp = {in_data[31] ^ in_sub, in_data[30:0]};
`else
   logic unused_sub;
   assign unused_sub = in_sub;
   assign smp        = in_data;
`endif

   assign in_ready  = (state == ACCEPT);
   assign dbg_state = state;

   // add_done is a level that can still be high from the previous operation.
   // The first WAIT cycle (wait_cnt == 0) therefore never takes it.
   assign done_ok   = (wait_cnt != '0) && add_done;
   assign count_inc = (&count) ? count : count + COUNT_W'(1);

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      count_nxt = count;
      abort_nxt = abort;
      case (state)
         ACCEPT: begin
            if (in_valid) begin
               if (first) begin
                  acc_nxt   = smp;
                  count_nxt = COUNT_W'(1);
                  abort_nxt = 1'b0;
                  if (in_last) state_nxt = OUT;
               end else begin
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (done_ok) begin
               acc_nxt   = add_sum;
               count_nxt = count_inc;
               state_nxt = last_q ? OUT : ACCEPT;
            end else if (wait_cnt == WAIT_LAST) begin
               // The aborted sample is dropped: acc and count are left as they are.
               abort_nxt = 1'b1;
               state_nxt = OUT;
            end
         end
         OUT: begin
            if (out_ready) state_nxt = ACCEPT;
         end
         default: state_nxt = ACCEPT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ACCEPT;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         first     <= 1'b1;
         last_q    <= 1'b0;
         abort     <= 1'b0;
         acc       <= '0;
         count     <= '0;
         wait_cnt  <= '0;
         add_start <= 1'b0;
         add_a     <= '0;
         add_b     <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         acc   <= acc_nxt;
         count <= count_nxt;
         abort <= abort_nxt;

         if (state == ACCEPT && in_valid) begin
            if (first) begin
               first <= 1'b0;
            end else begin
               // Operands stay stable from ISSUE until the next ISSUE.
               add_a  <= acc;
               add_b  <= smp;
               last_q <= in_last;
            end
         end
         if (state == OUT && out_ready) first <= 1'b1;

         if (state == ISSUE)
            wait_cnt <= '0;
         else if (state == WAIT && wait_cnt != WAIT_LAST)
            wait_cnt <= wait_cnt + TW'(1);

         // These outputs are registered from the next state, so they line up with it.
         add_start <= (state_nxt == ISSUE);
         busy      <= (state_nxt != ACCEPT);
         out_valid <= (state_nxt == OUT);

         // The result registers load only on entry to OUT. They then hold until
         // the next block reaches OUT.
         if (state != OUT && state_nxt == OUT) begin
            out_sum   <= acc_nxt;
            out_count <= count_nxt;
            err       <= abort_nxt;
         end
      end
   end

endmodule

// File: tb/tb_fpacc_seq.sv
// Testbench for fpacc_seq.
//
// The bench contains a behavioural fpadd model. Its latency is configurable,
// and it has three modes:
//   0 - normal: done is lowered on start.
//   1 - stale: done stays high one extra cycle after start.
//   2 - never: done never returns.
// Its sums come from a table of exactly representable pairs.
//
// Expected add_b operands and block results are queued when samples are
// driven. They are popped when the DUT issues an operation or hands over a
// result.
module tb_fpacc_seq;

   localparam int COUNT_W = 8;
   localparam int TIMEOUT = 64;

   logic               clk       = 1'b0;
   logic               reset     = 1'b0;
   logic               in_valid  = 1'b0;
   logic [31:0]        in_data   = '0;
   logic               in_last   = 1'b0;
   logic               in_sub    = 1'b0;
   logic               out_ready = 1'b1;
   logic [31:0]        add_sum   = '0;
   logic               add_done  = 1'b0;
   logic               in_ready;
   logic               add_start;
   logic [31:0]        add_a;
   logic [31:0]        add_b;
   logic               out_valid;
   logic [31:0]        out_sum;
   logic [COUNT_W-1:0] out_count;
   logic               err;
   logic               busy;
   logic [1:0]         dbg_state;

   fpacc_seq #(.COUNT_W(COUNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_sub    (in_sub),
      .add_start (add_start),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_sum   (add_sum),
      .add_done  (add_done),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .err       (err),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_cmp   = 0;
   int n_bad   = 0;
   int n_start = 0;
   logic [31:0] exp_b_q[$];
   logic [40:0] exp_q[$];   // {err, count, sum}
   logic        tb_first = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [63:0] act);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got 0x%0h", name, act);
   endtask

   // ---------------- fpadd model ----------------
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3F800000, 32'h40000000}: return 32'h40400000;
         {32'h40400000, 32'h3F000000}: return 32'h40600000;
         {32'h40000000, 32'h40000000}: return 32'h40800000;
         {32'h41200000, 32'h3F800000}: return 32'h41300000;
         {32'h41300000, 32'hC0000000}: return 32'h41100000;
         {32'h00000000, 32'h3F800000}: return 32'h3F800000;
         {32'h00000000, 32'h00000000}: return 32'h00000000;
         {32'h40000000, 32'hBF000000}: return 32'h3FC00000;
         {32'h40000000, 32'h3F000000}: return 32'h40200000;
         default:                      return 32'h7FC0DEAD;
      endcase
   endfunction

   int          lat_cfg    = 5;
   int          adder_mode = 0;
   logic        pend       = 1'b0;
   int          lat_cnt    = 0;
   logic [31:0] res        = '0;

   always @(posedge clk) begin
      if (add_start) begin
         pend    <= 1'b1;
         lat_cnt <= 1;
         res     <= fp_add(add_a, add_b);
         if (adder_mode != 1) add_done <= 1'b0;
      end else if (pend && adder_mode != 2) begin
         if (lat_cnt + 1 >= lat_cfg) begin
            add_done <= 1'b1;
            add_sum  <= res;
            pend     <= 1'b0;
         end else begin
            lat_cnt <= lat_cnt + 1;
            if (lat_cnt == 1) add_done <= 1'b0;
         end
      end
   end

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (reset && add_start) begin
         n_start++;
         if (exp_b_q.size() == 0) fail_now("add_start_extra", 64'(add_b));
         else check("add_b", 64'(add_b), 64'(exp_b_q.pop_front()));
      end
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) fail_now("out_extra", 64'(out_sum));
         else check("block_result", 64'({err, out_count, out_sum}), 64'(exp_q.pop_front()));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [31:0] d, input logic sub, input logic last,
                       input logic [31:0] esum, input logic [7:0] ecnt, input logic eerr);
      logic [31:0] smp;
      int k;
`ifdef FPACC_SUB_EN
      smp = {d[31] ^ sub, d[30:0]};
`else
      smp = d;
`endif
      in_valid = 1'b1;
      in_data  = d;
      in_sub   = sub;
      in_last  = last;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) fail_now("in_ready_wait", 64'(k));
      if (!tb_first) exp_b_q.push_back(smp);
      if (last) begin
         exp_q.push_back({eerr, ecnt, esum});
         tb_first = 1'b1;
      end else begin
         tb_first = 1'b0;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_sub   = 1'b0;
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || out_valid) && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (k >= 300) fail_now("drain_timeout", 64'(exp_q.size()));
      @(posedge clk);
      #1;
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [31:0] data;
      logic        last;
      logic [31:0] exp_sum;
      logic [7:0]  exp_cnt;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int s0;
      int nsamp;
      int cnt;

      vecs[0]  = '{32'h3F800000, 1'b0, 32'h0,        8'd0};
      vecs[1]  = '{32'h40000000, 1'b0, 32'h0,        8'd0};
      vecs[2]  = '{32'h3F000000, 1'b1, 32'h40600000, 8'd3};
      vecs[3]  = '{32'hC0400000, 1'b1, 32'hC0400000, 8'd1};
      vecs[4]  = '{32'h40000000, 1'b0, 32'h0,        8'd0};
      vecs[5]  = '{32'h40000000, 1'b1, 32'h40800000, 8'd2};
      vecs[6]  = '{32'h41200000, 1'b0, 32'h0,        8'd0};
      vecs[7]  = '{32'h3F800000, 1'b0, 32'h0,        8'd0};
      vecs[8]  = '{32'hC0000000, 1'b1, 32'h41100000, 8'd3};
      vecs[9]  = '{32'h00000000, 1'b0, 32'h0,        8'd0};
      vecs[10] = '{32'h3F800000, 1'b1, 32'h3F800000, 8'd2};

      // ---- reset ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_busy",      64'(busy),      64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_add_start", 64'(add_start), 64'd0);
      check("rst_result",    64'({err, out_count, out_sum}), 64'd0);
      check("rst_operands",  64'({add_a, add_b}), 64'd0);
      check("rst_state",     64'(dbg_state), 64'd0);
      @(posedge clk);
      #1;

      // ---- table-driven blocks ----
      s0    = n_start;
      nsamp = 0;
      for (int i = 0; i < 11; i++) begin
         lat_cfg = (i < 3) ? 5 : int'($urandom_range(2, 7));
         send(vecs[i].data, 1'b0, vecs[i].last, vecs[i].exp_sum, vecs[i].exp_cnt, 1'b0);
         nsamp++;
         if (vecs[i].last) begin
            wait_drain();
            check("starts_per_block", 64'(n_start - s0), 64'(nsamp - 1));
            s0    = n_start;
            nsamp = 0;
         end
      end

      // ---- count saturation: 300 zero samples ----
      lat_cfg = 2;
      for (int i = 0; i < 300; i++)
         send(32'h0, 1'b0, (i == 299), 32'h0, 8'hFF, 1'b0);
      wait_drain();

      // ---- single sample, result held while out_ready is low ----
      out_ready = 1'b0;
      s0 = n_start;
      send(32'hC0400000, 1'b0, 1'b1, 32'hC0400000, 8'd1, 1'b0);
      check("single_latency", 64'(out_valid), 64'd1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("stall_valid",    64'(out_valid), 64'd1);
         check("stall_result",   64'({err, out_count, out_sum}), 64'({1'b0, 8'd1, 32'hC0400000}));
         check("stall_in_ready", 64'(in_ready),  64'd0);
         check("stall_state",    64'(dbg_state), 64'd3);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_drain();
      check("single_no_start", 64'(n_start - s0), 64'd0);

      // ---- stale done from the previous operation ----
      adder_mode = 1;
      lat_cfg    = 5;
      send(32'h3F800000, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
      send(32'h40000000, 1'b0, 1'b1, 32'h40400000, 8'd2, 1'b0);
      wait_drain();
      adder_mode = 0;

      // ---- timeout: the adder never completes ----
      adder_mode = 2;
      send(32'h3F800000, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
      send(32'h40000000, 1'b0, 1'b1, 32'h3F800000, 8'd1, 1'b1);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!out_valid && cnt < 300);
      // ISSUE cycle + TIMEOUT WAIT cycles + the first OUT cycle
      check("timeout_cycles", 64'(cnt), 64'(TIMEOUT + 2));
      wait_drain();
      adder_mode = 0;

      // The next block clears err.
      lat_cfg = int'($urandom_range(2, 7));
      send(32'h40000000, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
      send(32'h40000000, 1'b0, 1'b1, 32'h40800000, 8'd2, 1'b0);
      wait_drain();

      // ---- reset in the middle of WAIT ----
      lat_cfg = 7;
      send(32'h3F800000, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
      send(32'h40000000, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      check("mid_rst_busy",      64'(busy),      64'd0);
      check("mid_rst_in_ready",  64'(in_ready),  64'd1);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_count",     64'(out_count), 64'd0);
      tb_first = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      lat_cfg = 3;
      send(32'h40000000, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
      send(32'h40000000, 1'b0, 1'b1, 32'h40800000, 8'd2, 1'b0);
      wait_drain();

      // ---- in_sub: negates the sample only when FPACC_SUB_EN is defined ----
      lat_cfg = 4;
      send(32'h40000000, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
`ifdef FPACC_SUB_EN
      send(32'h3F000000, 1'b1, 1'b1, 32'h3FC00000, 8'd2, 1'b0);
`else
      send(32'h3F000000, 1'b1, 1'b1, 32'h40200000, 8'd2, 1'b0);
`endif
      wait_drain();

      // ---- end ----
      repeat (2) @(negedge clk);
      check("exp_b_q_empty", 64'(exp_b_q.size()), 64'd0);
      check("exp_q_empty",   64'(exp_q.size()),   64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fpacc_seq.md
# fpacc_seq

Floating-point accumulation sequencer: the initiator side of the `fpadd` start/done handshake. It accepts a stream of IEEE-754 single-precision samples over a valid/ready input and issues one `fpadd` operation per sample, feeding back the running sum. It presents the block sum, with sample count and error status, over a valid/ready output. It sits between a sample source and one `fpadd` instance, which it drives exclusively.

## Interface

- `COUNT_W`, 8: width of the sample counter and `out_count`.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before the current operation is aborted. Must be at least 2.

- `clk` in 1: clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: the block accepts a sample this cycle.
- `in_data` in 32: sample, IEEE-754 single.
- `in_last` in 1: the sample is the final one of its block.
- `in_sub` in 1: negate the sample; used only under `FPACC_SUB_EN`.
- `add_start` out 1: start pulse to `fpadd`.
- `add_a` out 32: operand a, the running sum.
- `add_b` out 32: operand b, the new sample.
- `add_sum` in 32: `fpadd` result.
- `add_done` in 1: `fpadd` done flag. It is level, not a pulse, and stays high until the next start.
- `out_valid` out 1: the block result is valid.
- `out_ready` in 1: the consumer accepts the result.
- `out_sum` out 32: the block sum.
- `out_count` out COUNT_W: number of samples folded into `out_sum`. Saturates at all-ones.
- `err` out 1: the block was aborted by a timeout. Qualified by `out_valid`.
- `busy` out 1: high in any state except ACCEPT.

## Operation

- States: ACCEPT, ISSUE, WAIT, OUT. The reset state is ACCEPT, with the `first` flag set.
- Reset values:
  - All registered outputs are 0: `add_start`, `add_a`, `add_b`, `out_valid`, `out_sum`, `out_count`, `err`, `busy`.
  - `in_ready` equals `(state==ACCEPT)`, so it reads 1 once reset is released.
- Let `smp` be `in_data`, with bit 31 modified under `FPACC_SUB_EN` (see Configuration).
- ACCEPT, when `in_valid && in_ready`:
  - If `first`:
    - `acc <= smp`, `count <= 1`, `first <= 0`, `err <= 0`.
    - If `in_last`, go to OUT. Otherwise stay in ACCEPT.
    - No `fpadd` operation is issued for the first sample.
  - If not `first`:
    - `add_a <= acc`, `add_b <= smp`, latch `in_last` into `last_q`.
    - Go to ISSUE.
- ISSUE:
  - `add_start` is high for exactly this one cycle.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - `add_done` is ignored in the first WAIT cycle (guard cycle). This covers done still being high from the previous operation.
  - From the second cycle, on `add_done`:
    - `acc <= add_sum`, `count <= count+1`, saturating.
    - If `last_q`, go to OUT. Otherwise go to ACCEPT.
  - If the counter reaches TIMEOUT with no done:
    - `err <= 1`. `acc` and `count` are unchanged, so the aborted sample is dropped.
    - Go to OUT.
- OUT:
  - `out_valid` is 1, with `out_sum=acc`, `out_count=count`, `err` as set.
  - On `out_ready`: `out_valid <= 0`, `first <= 1`, go to ACCEPT.
  - `out_sum`, `out_count` and `err` hold their values until the next block reaches OUT.
- `add_a` and `add_b` hold stable from ISSUE until the next ISSUE.
- Special values (NaN, Inf, zero) are not inspected. Arithmetic is entirely `fpadd`'s.

## Timing

- The first sample of a block costs 1 cycle.
- Each further sample costs 1 (ACCEPT) + 1 (ISSUE) + L cycles, where L is the number of WAIT cycles up to and including the cycle `add_done` is sampled high. L is at least 2.
- `out_valid` rises on the clock edge that completes the last sample.
- `in_ready` is low in ISSUE, WAIT and OUT. There is no input buffering.
- `in_valid` held with `in_ready` low is not consumed. The sample is taken on the cycle `in_ready` is seen high.
- When `in_last` arrives on a first sample, the result is presented after 1 cycle with `out_count=1` and no `add_start`.
- Reset asserted in any state, including mid-WAIT:
  - Immediately returns to ACCEPT, clears `acc` and `count`, and sets `first`.
  - The in-flight `fpadd` result is discarded. `fpadd` is re-initialised by the next `add_start`.

## Configuration

- `FPACC_SUB_EN` defined: `smp = {in_data[31]^in_sub, in_data[30:0]}`. This applies to both the first and subsequent samples, so a block can mix additions and subtractions.
- `FPACC_SUB_EN` undefined: `smp = in_data`, and `in_sub` is ignored. The port remains present.

## Test plan

- Samples 0x3F800000, 0x40000000, 0x3F000000 (last), with an ideal adder model of 5-cycle latency -> two `add_start` pulses with `add_b` = 0x40000000 then 0x3F000000; `out_sum`=0x40600000, `out_count`=3, `err`=0.
- Single sample 0xC0400000 with `in_last` -> `out_valid` one cycle later with `out_sum`=0xC0400000, `out_count`=1; `add_start` never asserted.
- Adder model holds `add_done`=1 from the prior op and lowers it one cycle after start -> stale done is ignored in the guard cycle and the result is taken from the real completion.
- Adder never completes, TIMEOUT=64 -> after 64 WAIT cycles, `out_valid`=1, `err`=1, `out_sum`=first sample, `out_count`=1.
- `out_ready` low for 10 cycles in OUT -> `out_valid` and `out_sum` are stable and `in_ready`=0 throughout; `reset` pulsed low mid-WAIT -> `busy`=0, `in_ready`=1, `out_valid`=0 immediately.
- With `FPACC_SUB_EN`: 0x40000000 then 0x3F000000 with `in_sub`=1 (last) -> `add_b`=0xBF000000, `out_sum`=0x3FC00000.
